// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types, default parameters and helpers for regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_WIDTH    = 32;
    localparam int c_DEF_DEPTH    = 32;
    localparam int c_DEF_NREAD    = 2;
    localparam int c_DEF_ZERO_REG = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } regfile_state_t;

    // A depth of 1 still needs a one-bit address so port widths stay legal.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_if
// Brief    : Write/read/control bundle between pipeline and regfile_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int NREAD = c_DEF_NREAD
);
    localparam int AW = addr_width(DEPTH);

    logic                   RegWrite;
    logic [AW-1:0]          WriteRegister;
    logic [WIDTH-1:0]       WriteData;
    logic [NREAD*AW-1:0]    ReadRegister;
    logic [NREAD*WIDTH-1:0] ReadData;
    logic                   Clear;
    logic                   Busy;
    logic                   WriteDrop;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister, Clear,
        input  ReadData, Busy, WriteDrop
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister, Clear,
        output ReadData, Busy, WriteDrop
    );

endinterface : regfile_if
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Brief    : One combinational read port: address mux, optional write-first
//            bypass (REGFILE_BYPASS_EN) and zero/Busy masking.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int DEPTH    = c_DEF_DEPTH,
    parameter int ZERO_REG = c_DEF_ZERO_REG,
    localparam int AW      = addr_width(DEPTH)
) (
    input  wire  [WIDTH-1:0] i_mem [DEPTH],
    input  wire  [AW-1:0]    i_rd_addr,
    input  wire              i_busy,
`ifdef REGFILE_BYPASS_EN
    input  wire              i_wr_en,
    input  wire  [AW-1:0]    i_wr_addr,
    input  wire  [WIDTH-1:0] i_wr_data,
`endif
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] w_raw;
    logic             w_zero;

    always_comb begin
        w_raw = i_mem[i_rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (i_wr_en && !i_busy && (i_wr_addr == i_rd_addr)) begin
            w_raw = i_wr_data;
        end
`endif
    end

    assign w_zero    = i_busy || ((ZERO_REG != 0) && (i_rd_addr == '0));
    assign o_rd_data = w_zero ? '0 : w_raw;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-read-port register file with a hardware
//            zeroing sweep after reset or Clear. Optional write-first read
//            bypass selected by REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int DEPTH    = c_DEF_DEPTH,
    parameter int NREAD    = c_DEF_NREAD,
    parameter int ZERO_REG = c_DEF_ZERO_REG
) (
    input wire        Clk,
    input wire        Reset_n,
    regfile_if.slave  bus
);

    localparam int            AW     = addr_width(DEPTH);
    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    regfile_state_t   r_state;
    regfile_state_t   w_state_nxt;
    logic [AW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_write_drop;
    logic             w_busy;
    logic             w_user_we;
    logic             w_drop;
    logic [WIDTH-1:0] w_rd [NREAD];

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= SWEEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.Clear)         w_state_nxt = SWEEP;
            SWEEP:   if (r_count == c_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = SWEEP;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state == SWEEP);
    end

    // Counter wraps to zero naturally on the final sweep entry (DEPTH is 2^n).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (w_busy) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_user_we = !w_busy && bus.RegWrite && !bus.Clear &&
                       !((ZERO_REG != 0) && (bus.WriteRegister == '0));
    assign w_drop    = bus.RegWrite && (w_busy || bus.Clear);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_write_drop <= 1'b0;
        end else begin
            r_write_drop <= w_drop;
        end
    end

    // Storage is reset-free so it can map onto RAM.
    always_ff @(posedge Clk) begin
        if (w_busy) begin
            r_mem[r_count] <= '0;
        end else if (w_user_we) begin
            r_mem[bus.WriteRegister] <= bus.WriteData;
        end
    end

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_read
            regfile_read_port #(
                .WIDTH    (WIDTH),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG)
            ) u_read_port (
                .i_mem     (r_mem),
                .i_rd_addr (bus.ReadRegister[k*AW +: AW]),
                .i_busy    (w_busy),
`ifdef REGFILE_BYPASS_EN
                .i_wr_en   (bus.RegWrite),
                .i_wr_addr (bus.WriteRegister),
                .i_wr_data (bus.WriteData),
`endif
                .o_rd_data (w_rd[k])
            );
            assign bus.ReadData[k*WIDTH +: WIDTH] = w_rd[k];
        end
    endgenerate

    assign bus.Busy      = w_busy;
    assign bus.WriteDrop = r_write_drop;

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Scoreboard bench for regfile_mp against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int N  = 3;
    localparam int ZR = 1;
    localparam int AW = addr_width(D);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_if #(.WIDTH(W), .DEPTH(D), .NREAD(N)) bus ();

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(N), .ZERO_REG(ZR)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic           busy;
        logic           drop;
        logic [N*W-1:0] rd;
        bit             fixed;
        logic [N*W-1:0] fval;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model: contents, cycles of sweep still to run, pending drop flag.
    logic [W-1:0] mem_m [D];
    int           busy_left = D;
    bit           drop_q    = 1'b0;

    task automatic zero_model();
        for (int i = 0; i < D; i++) mem_m[i] = '0;
    endtask

    task automatic step(input bit rn, input bit we, input int wa,
                        input logic [W-1:0] wd, input bit clr,
                        input int ra0, input int ra1, input int ra2,
                        input string nm, input bit fx = 1'b0,
                        input logic [N*W-1:0] fv = '0);
        exp_t e;
        int   ra [N];
        logic [W-1:0] v;
        @(posedge clk);
        #1;
        ra[0] = ra0 & (D-1);
        ra[1] = ra1 & (D-1);
        ra[2] = ra2 & (D-1);
        wa    = wa & (D-1);
        rst_n             = rn;
        bus.RegWrite      = we;
        bus.WriteRegister = AW'(wa);
        bus.WriteData     = wd;
        bus.Clear         = clr;
        for (int k = 0; k < N; k++) bus.ReadRegister[k*AW +: AW] = AW'(ra[k]);

        e.busy = !rn || (busy_left > 0);
        e.drop = rn && drop_q;
        for (int k = 0; k < N; k++) begin
            if (e.busy)                          v = '0;
            else if (ZR != 0 && ra[k] == 0)      v = '0;
            else if (BYP && we && ra[k] == wa)   v = wd;
            else                                 v = mem_m[ra[k]];
            e.rd[k*W +: W] = v;
        end
        e.fixed = fx;
        e.fval  = fv;
        e.name  = nm;
        sb.push_back(e);

        if (!rn) begin
            busy_left = D;
            drop_q    = 1'b0;
            zero_model();
        end else begin
            drop_q = we && (busy_left > 0 || clr);
            if (busy_left > 0) begin
                busy_left--;
            end else if (clr) begin
                busy_left = D;
                zero_model();
            end else if (we && !(ZR != 0 && wa == 0)) begin
                mem_m[wa] = wd;
            end
        end
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 0, '0, 1'b0, $urandom, $urandom, $urandom, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bus.Busy !== e.busy) begin
                    bad++;
                    $display("FAIL %s busy: got %0b want %0b", e.name, bus.Busy, e.busy);
                end
                total++;
                if (bus.WriteDrop !== e.drop) begin
                    bad++;
                    $display("FAIL %s writedrop: got %0b want %0b", e.name, bus.WriteDrop, e.drop);
                end
                for (int k = 0; k < N; k++) begin
                    total++;
                    if (bus.ReadData[k*W +: W] !== e.rd[k*W +: W]) begin
                        bad++;
                        $display("FAIL %s rd%0d: got %h want %h", e.name, k,
                                 bus.ReadData[k*W +: W], e.rd[k*W +: W]);
                    end
                end
                if (e.fixed) begin
                    total++;
                    if (bus.ReadData !== e.fval) begin
                        bad++;
                        $display("FAIL %s plan: got %h want %h", e.name, bus.ReadData, e.fval);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst_n             = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.Clear         = 1'b0;
        bus.ReadRegister  = '0;

        // Reset, then the full power-on sweep
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 0, '0, 1'b0, $urandom, $urandom, $urandom, "reset");
        idle("rst_sweep", D);
        idle("post_sweep", 1);

        // Basic write / readback, zero register
        step(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, 1, 1, 1, "wr5");
        step(1'b1, 1'b0, 0, '0, 1'b0, 5, 0, 0, "rd5", 1'b1, {32'h0, 32'h0, 32'hDEADBEEF});
        step(1'b1, 1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0, "wr0");
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 0, 0, "rd0", 1'b1, '0);

        // Same-cycle write/read of one address
        step(1'b1, 1'b1, 7, 32'h1, 1'b0, 1, 2, 3, "wr7_old");
        step(1'b1, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 7, 7, 7, "byp7", 1'b1,
             BYP ? {3{32'hA5A5A5A5}} : {3{32'h00000001}});
        step(1'b1, 1'b0, 0, '0, 1'b0, 7, 7, 7, "rd7", 1'b1, {3{32'hA5A5A5A5}});

        // Fill, then Clear colliding with a write
        for (int r = 1; r < D; r++)
            step(1'b1, 1'b1, r, $urandom, 1'b0, r, r - 1, $urandom, "fill");
        step(1'b1, 1'b1, 3, 32'hCAFEF00D, 1'b1, 3, 5, 7, "clr_wr3");
        idle("clr_sweep", D);
        for (int r = 0; r < D; r += 3)
            step(1'b1, 1'b0, 0, '0, 1'b0, r, r + 1, r + 2, "clr_zero", 1'b1, '0);

        // Reset at sweep index 10; writes during the sweep must be dropped
        step(1'b1, 1'b0, 0, '0, 1'b1, 0, 0, 0, "clr2");
        idle("sweep10", 10);
        step(1'b0, 1'b1, 4, $urandom, 1'b0, 4, 4, 4, "midrst");
        step(1'b0, 1'b0, 0, '0, 1'b0, 4, 4, 4, "midrst");
        for (int i = 0; i < D; i++)
            step(1'b1, (i % 5) == 0, $urandom, $urandom, 1'b0,
                 $urandom, $urandom, $urandom, "rst_resweep");
        idle("resweep_done", 2);

        // Randomised traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
                 $urandom, $urandom, $urandom_range(0, 39) == 0,
                 $urandom, $urandom, $urandom, "rand");

        idle("tail", 2);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
